// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception/interrupt arbiter and CP0.
// Holds cause codes, arbiter state encoding and the default handler vector.
package exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTER = 2'd1,
    ST_REDIR = 2'd2
  } exc_state_t;

  // Decode-stage exceptions ranked RI > Syscall > Break; falls back to interrupt.
  function automatic logic [4:0] exc_code_sel(input logic ri, input logic sys, input logic brk);
    if (ri)       return EXC_RI;
    else if (sys) return EXC_SYS;
    else if (brk) return EXC_BP;
    else          return EXC_INT;
  endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Interrupt-line input stage: two flops per bit with EXC_INT_SYNC_EN defined,
// otherwise a single register stage for sources already on Clk.
module int_sync #(
  parameter int WIDTH = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

`ifdef EXC_INT_SYNC_EN
  logic [WIDTH-1:0] meta;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
`else
  always_ff @(posedge Clk) begin
    if (Reset) q <= '0;
    else       q <= d;
  end
`endif

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt arbiter feeding CP0 and the control FSM redirect.
// Optional macro EXC_INT_SYNC_EN selects a two-flop interrupt synchronizer.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int          NUM_HWINT  = 6
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_HWINT-1:0] HWIntIn,
  input  logic [NUM_HWINT-1:0] SR_IM,
  input  logic                 SR_ie,
  input  logic                 SR_exl,
  input  logic                 InstrBoundary,
  input  logic                 DecValid,
  input  logic                 ExcRI,
  input  logic                 ExcSyscall,
  input  logic                 ExcBreak,
  input  logic [31:0]          CurPC,
  input  logic                 RedirAck,
  output logic                 ExcEnter,
  output logic [4:0]           ExcCode,
  output logic [NUM_HWINT-1:0] HWInt,
  output logic [31:0]          ExcPC,
  output logic                 RedirReq,
  output logic [31:0]          VecPC
);

  exc_state_t           state;
  logic [NUM_HWINT-1:0] hw_int_sync;
  logic [NUM_HWINT-1:0] pend;
  logic                 int_req;
  logic                 sync_req;

  int_sync #(.WIDTH(NUM_HWINT)) u_int_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (HWIntIn),
    .q     (hw_int_sync)
  );

  assign pend     = hw_int_sync & SR_IM;
  assign int_req  = InstrBoundary & SR_ie & ~SR_exl & (|pend);
  assign sync_req = DecValid & (ExcRI | ExcSyscall | ExcBreak);
  assign VecPC    = EXC_VECTOR;

  // Requests seen outside IDLE are dropped; the stalled FSM re-presents them.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      ExcEnter <= 1'b0;
      RedirReq <= 1'b0;
      ExcCode  <= EXC_INT;
      HWInt    <= '0;
      ExcPC    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sync_req | int_req) begin
            state    <= ST_ENTER;
            ExcEnter <= 1'b1;
            RedirReq <= 1'b1;
            ExcCode  <= sync_req ? exc_code_sel(ExcRI, ExcSyscall, ExcBreak) : EXC_INT;
            HWInt    <= pend;
            ExcPC    <= CurPC;
          end
        end
        ST_ENTER: begin
          state    <= ST_REDIR;
          ExcEnter <= 1'b0;
        end
        ST_REDIR: begin
          if (RedirAck) begin
            state    <= ST_IDLE;
            RedirReq <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          ExcEnter <= 1'b0;
          RedirReq <= 1'b0;
        end
      endcase
    end
  end

endmodule
